// File: rtl/vga_scan_gen.sv
// Raster timing generator: column/row counters, sync pulses, visible-area flag and frame tick.
// Optional feature macro VGA_PIXDIV2_EN: divide the clock by 2 to get the pixel rate.
module vga_scan_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_en,
  output logic [9:0] height,
  output logic [9:0] width,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_active;
  logic       r_tick;

  logic       w_adv;
  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_wrap;

`ifdef VGA_PIXDIV2_EN
  logic r_phase;

  always_ff @(posedge clk) begin
    if (!rst) r_phase <= 1'b0;
    else      r_phase <= ~r_phase;
  end

  assign w_adv = r_phase;
`else
  assign w_adv = 1'b1;
`endif

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_wrap   = w_adv && w_h_last && w_v_last;

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_adv) begin
      if (w_h_last) begin
        w_h_nxt = 10'd0;
        w_v_nxt = w_v_last ? 10'd0 : r_v + 10'd1;
      end else begin
        w_h_nxt = r_h + 10'd1;
      end
    end
  end

  // Flags are derived from the next-state coordinates so they land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h      <= 10'd0;
      r_v      <= 10'd0;
      r_hsync  <= ~HS_POL;
      r_vsync  <= ~VS_POL;
      r_active <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_hsync  <= (w_h_nxt >= HS_BEG && w_h_nxt <= HS_END) ? HS_POL : ~HS_POL;
      r_vsync  <= (w_v_nxt >= VS_BEG && w_v_nxt <= VS_END) ? VS_POL : ~VS_POL;
      r_active <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      r_tick   <= w_wrap;
    end
  end

  assign pixel_en   = w_adv;
  assign height     = r_h;
  assign width      = r_v;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign active     = r_active;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a default 640x480 instance and a tiny-raster instance, both
// compared every clock against an arithmetic model driven by the clock count since reset.
module tb_vga_scan_gen;

`ifdef VGA_PIXDIV2_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic       tk;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  logic       pe_a, hs_a, vs_a, act_a, tk_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, hs_b, vs_b, act_b, tk_b;
  logic [9:0] h_b, v_b;

  int     checks = 0;
  int     errors = 0;
  longint ka = 0;
  longint kb = 0;

  always #5 clk = ~clk;

  vga_scan_gen u_dut_a (
    .clk(clk), .rst(rst_a), .pixel_en(pe_a), .height(h_a), .width(v_a),
    .hsync(hs_a), .vsync(vs_a), .active(act_a), .frame_tick(tk_a)
  );

  vga_scan_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .pixel_en(pe_b), .height(h_b), .width(v_b),
    .hsync(hs_b), .vsync(vs_b), .active(act_b), .frame_tick(tk_b)
  );

  function automatic longint adv_of(longint k);
    return DIV ? k / 2 : k;
  endfunction

  // Position follows from the number of pixel advances since reset release.
  function automatic obs_t model(longint k, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb);
    obs_t   o;
    longint adv, ht, vt, h, v;
    adv  = adv_of(k);
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = adv % ht;
    v    = (adv / ht) % vt;
    o.pe = DIV ? ((k % 2 == 1) ? 1'b1 : 1'b0) : 1'b1;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = (h >= ha + hf && h < ha + hf + hs) ? 1'b0 : 1'b1;
    o.vs = (v >= va + vf && v < va + vf + vs) ? 1'b0 : 1'b1;
    o.act = (h < ha && v < va) ? 1'b1 : 1'b0;
    o.tk = (k > 0 && (!DIV || k % 2 == 0) && adv % (ht * vt) == 0) ? 1'b1 : 1'b0;
    return o;
  endfunction

  task automatic chk1(string tag, logic [9:0] obs, logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (ka=%0d kb=%0d)", tag, obs, exp, ka, kb);
    end
  endtask

  task automatic check_obs(string tag, obs_t o, obs_t e);
    chk1({tag, ".pixel_en"}, 10'(o.pe), 10'(e.pe));
    chk1({tag, ".height"}, o.h, e.h);
    chk1({tag, ".width"}, o.v, e.v);
    chk1({tag, ".hsync"}, 10'(o.hs), 10'(e.hs));
    chk1({tag, ".vsync"}, 10'(o.vs), 10'(e.vs));
    chk1({tag, ".active"}, 10'(o.act), 10'(e.act));
    chk1({tag, ".frame_tick"}, 10'(o.tk), 10'(e.tk));
  endtask

  task automatic step(logic ra, logic rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    ka = ra ? ka + 1 : 0;
    kb = rb ? kb + 1 : 0;
    #1;
    check_obs("A", obs_t'{pe_a, h_a, v_a, hs_a, vs_a, act_a, tk_a},
              model(ka, 640, 16, 96, 48, 480, 10, 2, 33));
    check_obs("B", obs_t'{pe_b, h_b, v_b, hs_b, vs_b, act_b, tk_b},
              model(kb, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
  endtask

  function automatic logic rand_rb();
    return ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic bit b_in_both_syncs();
    longint adv, h, v;
    adv = adv_of(kb);
    h   = adv % (SHA + SHF + SHS + SHB);
    v   = (adv / (SHA + SHF + SHS + SHB)) % (SVA + SVF + SVS + SVB);
    return (h >= SHA + SHF && h < SHA + SHF + SHS && v >= SVA + SVF && v < SVA + SVF + SVS);
  endfunction

  initial begin
    longint adv0;
    int n;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk1("rst.height", h_a, 10'd0);
    chk1("rst.width", v_a, 10'd0);
    chk1("rst.hsync", 10'(hs_a), 10'd1);
    chk1("rst.vsync", 10'(vs_a), 10'd1);
    chk1("rst.active", 10'(act_a), 10'd1);
    chk1("rst.frame_tick", 10'(tk_a), 10'd0);
    chk1("rst.pixel_en", 10'(pe_a), DIV ? 10'd0 : 10'd1);

    // First advance after release.
    step(1'b1, 1'b1);
    if (DIV) begin
      chk1("rel1.height", h_a, 10'd0);
      step(1'b1, 1'b1);
    end
    chk1("rel.height", h_a, 10'd1);

    // Run to (799,10) with random resets on the small instance.
    n = 0;
    while (adv_of(ka) < 10 * 800 + 799 && n < 20000) begin
      step(1'b1, rand_rb());
      n++;
    end
    chk1("reach.799_10", h_a, 10'd799);
    chk1("reach.row10", v_a, 10'd10);

    // Line wrap.
    adv0 = adv_of(ka);
    n = 0;
    while (adv_of(ka) == adv0 && n < 4) begin
      step(1'b1, rand_rb());
      n++;
    end
    chk1("wrap.height", h_a, 10'd0);
    chk1("wrap.width", v_a, 10'd11);
    chk1("wrap.active", 10'(act_a), 10'd1);

    // Mid-line reset of the default instance while hsync is asserted.
    n = 0;
    while (adv_of(ka) % 800 != 700 && n < 2000) begin
      step(1'b1, rand_rb());
      n++;
    end
    chk1("mid.hsync_low", 10'(hs_a), 10'd0);
    step(1'b0, rand_rb());
    chk1("mid.height", h_a, 10'd0);
    chk1("mid.hsync", 10'(hs_a), 10'd1);
    chk1("mid.tick", 10'(tk_a), 10'd0);

    // Small instance: reset while both syncs are asserted.
    n = 0;
    while (!b_in_both_syncs() && n < 1000) begin
      step(1'b1, 1'b1);
      n++;
    end
    chk1("midB.hsync_low", 10'(hs_b), 10'd0);
    chk1("midB.vsync_low", 10'(vs_b), 10'd0);
    step(1'b1, 1'b0);
    chk1("midB.height", h_b, 10'd0);
    chk1("midB.width", v_b, 10'd0);
    chk1("midB.hsync", 10'(hs_b), 10'd1);
    chk1("midB.vsync", 10'(vs_b), 10'd1);
    chk1("midB.tick", 10'(tk_b), 10'd0);

    // Uninterrupted frames on the small instance, then random resets on both.
    for (int i = 0; i < 1200; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) step(($urandom_range(0, 999) != 0) ? 1'b1 : 1'b0, rand_rb());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
